// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 pooling over CH parallel signed channels using a half-width line buffer.
// Define MAXPOOL_AVG_EN to build average pooling instead of max pooling.
module maxpool2x2_stream #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [CH*WIDTH-1:0]   in_data,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic [CH*WIDTH-1:0]   out_data,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int LBA   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MAXPOOL_AVG_EN
    localparam int LBW   = WIDTH + 1;
`else
    localparam int LBW   = WIDTH;
`endif

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    logic [0:0]            r_state;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [CH*WIDTH-1:0]   r_hold;
    logic [CH*LBW-1:0]     r_lineBuf [DEPTH];

    logic                  w_accept;
    logic                  w_emit;
    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic [LBA-1:0]        w_lbIdx;
    logic [CH*LBW-1:0]     w_hAll;
    logic [CH*WIDTH-1:0]   w_yAll;

    // A start-of-frame pixel always restarts at (0,0), whether or not a frame was in progress.
    assign w_accept = in_valid && (in_sof || (r_state == RUN));
    assign w_col    = in_sof ? '0 : r_col;
    assign w_row    = in_sof ? '0 : r_row;
    assign w_lbIdx  = LBA'(w_col >> 1);
    assign w_emit   = w_accept && w_col[0] && w_row[0];

    genvar k;
    for (k = 0; k < CH; k++) begin : g_ch
        logic signed [WIDTH-1:0] w_x;
        logic signed [WIDTH-1:0] w_p;
        logic signed [LBW-1:0]   w_lb;
        logic signed [LBW-1:0]   w_h;
        logic signed [WIDTH-1:0] w_y;

        assign w_x  = in_data[k*WIDTH +: WIDTH];
        assign w_p  = r_hold[k*WIDTH +: WIDTH];
        assign w_lb = r_lineBuf[w_lbIdx][k*LBW +: LBW];
`ifdef MAXPOOL_AVG_EN
        logic signed [WIDTH+1:0] w_sum;
        logic signed [WIDTH+1:0] w_shift;
        assign w_h     = {w_p[WIDTH-1], w_p} + {w_x[WIDTH-1], w_x};
        assign w_sum   = {w_lb[LBW-1], w_lb} + {w_h[LBW-1], w_h};
        assign w_shift = w_sum >>> 2;
        assign w_y     = w_shift[WIDTH-1:0];
`else
        assign w_h = (w_x > w_p) ? w_x : w_p;
        assign w_y = (w_lb > w_h) ? w_lb : w_h;
`endif
        assign w_hAll[k*LBW +: LBW]     = w_h;
        assign w_yAll[k*WIDTH +: WIDTH] = w_y;
    end

    // Line buffer carries no reset; each entry is rewritten on an even row before any odd-row read.
    always_ff @(posedge clk) begin
        if (w_accept && w_col[0] && !w_row[0]) begin
            r_lineBuf[w_lbIdx] <= w_hAll;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT_SOF;
            r_col      <= '0;
            r_row      <= '0;
            r_hold     <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err  <= in_valid && in_sof && (r_state == RUN);
            out_valid  <= w_emit;
            out_sof    <= w_emit && (w_col == CW'(1)) && (w_row == RW'(1));
            out_eol    <= w_emit && (w_col == CW'(IMG_W - 1));
            frame_done <= w_emit && (w_col == CW'(IMG_W - 1)) && (w_row == RW'(IMG_H - 1));
            if (w_emit) begin
                out_data <= w_yAll;
            end
            if (w_accept) begin
                if (!w_col[0]) begin
                    r_hold <= in_data;
                end
                if (w_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    if (w_row == RW'(IMG_H - 1)) begin
                        r_row   <= '0;
                        r_state <= WAIT_SOF;
                    end else begin
                        r_row   <= w_row + RW'(1);
                        r_state <= RUN;
                    end
                end else begin
                    r_col   <= w_col + CW'(1);
                    r_row   <= w_row;
                    r_state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: directed and random frames checked against a whole-frame reference model.
module tb_maxpool2x2_stream;

    localparam int WIDTH = 8;
    localparam int CH    = 2;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int DW    = CH * WIDTH;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;
    logic [DW-1:0] out_data;
    logic          frame_done;
    logic          frame_err;

    int nCompared = 0;
    int nFail     = 0;

    logic [DW-1:0] frameBuf [NPIX];

    // Reference model: remembers the whole current frame and pools straight from it.
    bit            mRun;
    int            mCol;
    int            mRow;
    logic [DW-1:0] mFrame [IMG_H][IMG_W];
    logic          expValid, expSof, expEol, expDone, expErr;
    logic [DW-1:0] expData;

    maxpool2x2_stream #(
        .WIDTH(WIDTH), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_data   (out_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] poolModel(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW-1:0]    res;
        logic [WIDTH-1:0] tmp;
        int va, vb, vc, vd, r;
        res = '0;
        for (int k = 0; k < CH; k++) begin
            va = int'($signed(a[k*WIDTH +: WIDTH]));
            vb = int'($signed(b[k*WIDTH +: WIDTH]));
            vc = int'($signed(c[k*WIDTH +: WIDTH]));
            vd = int'($signed(d[k*WIDTH +: WIDTH]));
`ifdef MAXPOOL_AVG_EN
            r = (va + vb + vc + vd) >>> 2;
`else
            r = va;
            if (vb > r) r = vb;
            if (vc > r) r = vc;
            if (vd > r) r = vd;
`endif
            tmp = r[WIDTH-1:0];
            res[k*WIDTH +: WIDTH] = tmp;
        end
        return res;
    endfunction

    task automatic modelReset();
        mRun     = 1'b0;
        mCol     = 0;
        mRow     = 0;
        expValid = 1'b0;
        expSof   = 1'b0;
        expEol   = 1'b0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        expData  = '0;
    endtask

    task automatic modelStep(input logic v, input logic s, input logic [DW-1:0] d);
        expErr   = v && s && mRun;
        expValid = 1'b0;
        expSof   = 1'b0;
        expEol   = 1'b0;
        expDone  = 1'b0;
        if (v && (s || mRun)) begin
            if (s) begin
                mCol = 0;
                mRow = 0;
            end
            mFrame[mRow][mCol] = d;
            if ((mCol % 2 == 1) && (mRow % 2 == 1)) begin
                expValid = 1'b1;
                expData  = poolModel(mFrame[mRow-1][mCol-1], mFrame[mRow-1][mCol],
                                     mFrame[mRow][mCol-1],   mFrame[mRow][mCol]);
                expSof   = (mCol == 1) && (mRow == 1);
                expEol   = (mCol == IMG_W - 1);
                expDone  = (mCol == IMG_W - 1) && (mRow == IMG_H - 1);
            end
            mRun = 1'b1;
            mCol++;
            if (mCol == IMG_W) begin
                mCol = 0;
                mRow++;
                if (mRow == IMG_H) begin
                    mRow = 0;
                    mRun = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        nCompared++;
        assert (out_valid === expValid) else begin
            nFail++;
            $error("FAIL %s out_valid: observed %0b expected %0b", tag, out_valid, expValid);
        end
        nCompared++;
        assert (out_data === expData) else begin
            nFail++;
            $error("FAIL %s out_data: observed %h expected %h", tag, out_data, expData);
        end
        nCompared++;
        assert (out_sof === expSof) else begin
            nFail++;
            $error("FAIL %s out_sof: observed %0b expected %0b", tag, out_sof, expSof);
        end
        nCompared++;
        assert (out_eol === expEol) else begin
            nFail++;
            $error("FAIL %s out_eol: observed %0b expected %0b", tag, out_eol, expEol);
        end
        nCompared++;
        assert (frame_done === expDone) else begin
            nFail++;
            $error("FAIL %s frame_done: observed %0b expected %0b", tag, frame_done, expDone);
        end
        nCompared++;
        assert (frame_err === expErr) else begin
            nFail++;
            $error("FAIL %s frame_err: observed %0b expected %0b", tag, frame_err, expErr);
        end
    endtask

    // Called at 1 time unit after a rising edge; leaves the bench at the same phase.
    task automatic applyCycle(input logic v, input logic s, input logic [DW-1:0] d, input string tag);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        modelStep(v, s, d);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input int n, input int gap, input int sofIdx, input string tag);
        for (int i = 0; i < n; i++) begin
            applyCycle(1'b1, (i == sofIdx), frameBuf[i], tag);
            for (int g = 0; g < gap; g++) begin
                applyCycle(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), tag);
            end
        end
    endtask

    task automatic applyReset(input string tag);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        modelReset();
        #2;
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
        reset = 1'b0;
    endtask

    task automatic fillBasic();
        for (int i = 0; i < NPIX; i++) begin
            frameBuf[i] = DW'($urandom);
            frameBuf[i][WIDTH-1:0] = WIDTH'(i + 1);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NPIX; i++) begin
            frameBuf[i] = DW'($urandom);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        modelReset();
        @(posedge clk);
        #1;
        applyReset("reset");

        fillBasic();
        applyStimulus(NPIX, 0, 0, "basic");
        for (int i = 0; i < 3; i++) applyCycle(1'b0, 1'b0, '0, "basicIdle");

        fillRandom();
        frameBuf[0][WIDTH-1:0] = WIDTH'(-5);
        frameBuf[1][WIDTH-1:0] = WIDTH'(-3);
        frameBuf[4][WIDTH-1:0] = WIDTH'(-128);
        frameBuf[5][WIDTH-1:0] = WIDTH'(-1);
        frameBuf[2][WIDTH-1:0] = WIDTH'(127);
        frameBuf[3][WIDTH-1:0] = WIDTH'(-128);
        frameBuf[6][WIDTH-1:0] = WIDTH'(0);
        frameBuf[7][WIDTH-1:0] = WIDTH'(0);
        applyStimulus(NPIX, 0, 0, "signed");

        fillBasic();
        applyStimulus(NPIX, 3, 0, "bubbles");

        applyReset("reset2");
        fillRandom();
        applyStimulus(NPIX, 0, -1, "noSof");
        fillBasic();
        applyStimulus(NPIX, 1, 0, "afterNoSof");

        fillBasic();
        applyStimulus(9, 0, 0, "abortHead");
        fillRandom();
        applyStimulus(NPIX, 0, 0, "abortNew");

        fillRandom();
        applyStimulus(NPIX - 1, 0, 0, "lastHead");
        fillRandom();
        applyStimulus(NPIX, 0, 0, "lastSof");

        for (int f = 0; f < 6; f++) begin
            fillRandom();
            applyStimulus(NPIX, $urandom_range(0, 2), 0, "random");
        end

        fillRandom();
        applyStimulus(6, 0, 0, "preReset");
        applyReset("midRowReset");
        fillRandom();
        applyStimulus(8, 0, -1, "postReset");
        fillRandom();
        applyStimulus(NPIX, 0, 0, "final");
        for (int i = 0; i < 2; i++) applyCycle(1'b0, 1'b0, '0, "finalIdle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 pooling stage. Sits directly downstream of the convolution filter chain and consumes its per-channel pixel outputs.
- Receives CH parallel signed channels in raster order, one pixel per valid cycle. Emits one pooled pixel per channel for every 2x2 input block.
- Uses a half-width line buffer, so a full frame is never stored.
- Output feeds the next conv layer, or the readout.

Parameters:
- WIDTH, 16, bit width of each signed sample.
- CH, 4, number of parallel channels; all channels share control.
- IMG_W, 32, input line length in pixels; must be even and at least 2.
- IMG_H, 32, input frame height in lines; must be even and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel strobe; no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
- in_data  in  CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH], signed.
- out_valid  out  1  pooled pixel strobe.
- out_sof  out  1  first pooled pixel of the frame.
- out_eol  out  1  last pooled pixel of a pooled line.
- out_data  out  CH*WIDTH  pooled samples, same packing as in_data.
- frame_done  out  1  one-cycle pulse with the last pooled pixel of the frame.
- frame_err  out  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Reset: All outputs go to 0. col, row and the state register clear; state = WAIT_SOF. Line buffer contents are not reset.
- FSM states: WAIT_SOF and RUN.
- WAIT_SOF:
  - A pixel with in_valid=1 and in_sof=0 is ignored.
  - A pixel with in_valid=1 and in_sof=1 is processed as (0,0), then state becomes RUN.
- RUN:
  - Each in_valid pixel is processed at the current (col,row).
  - col increments and wraps from IMG_W-1 to 0. On wrap, row increments.
  - After pixel (IMG_W-1, IMG_H-1): col=0, row=0, state becomes WAIT_SOF.
- in_sof during RUN:
  - frame_err pulses for 1 cycle.
  - The pixel is treated as (0,0) of a new frame.
  - Partial output of the aborted frame is simply truncated; no flush.
- Per channel, on each accepted pixel x:
  - col even: store x in hold register p.
  - col odd: h = max(p, x).
    - row even: linebuf[col>>1] = h.
    - row odd: y = max(linebuf[col>>1], h).
- All comparisons are signed two's complement.
- Line buffer depth is IMG_W/2 and width is CH*WIDTH. Single write or read per cycle, with the read in the same cycle as h is formed. Either a register array or inferred RAM with registered output is acceptable, provided latency is met.
- Output timing:
  - Latency: out_valid asserts exactly 1 cycle after the accepted pixel at odd col and odd row.
  - out_valid is 0 in every other cycle.
  - out_data holds its value when out_valid=0.
- Output markers:
  - out_sof=1 with the pooled pixel produced by input (1,1).
  - out_eol=1 with the pooled pixel from col=IMG_W-1 on any odd row.
  - frame_done=1 together with the pooled pixel from (IMG_W-1, IMG_H-1).
- Gaps: in_valid may deassert for any number of cycles anywhere, including mid-pair and between rows. All state holds during the gap.
- Simultaneous events: in_sof on the last pixel of a frame is a new frame.
  - The final pooled pixel of the old frame is not produced, because the pixel is reinterpreted as (0,0).
  - frame_err pulses.
- Reset mid-frame: everything returns to WAIT_SOF, and any pending output is dropped.

Optional Feature:
- Macro: MAXPOOL_AVG_EN.
- Defined: average pooling replaces max.
  - h = p + x, kept at WIDTH+1 bits.
  - Line buffer stores the WIDTH+1-bit h.
  - y = (linebuf + h) computed at WIDTH+2 bits, then arithmetic shift right by 2 (floor), then truncated to WIDTH.
  - Timing and control are identical to max mode.
- Not defined: max pooling exactly as in Behaviour; line buffer is WIDTH bits per channel.

Test Plan:
- Basic max, CH=1, WIDTH=8, 4x4, one pixel per cycle, frame 1..16 raster, sof on the first pixel -> four outputs 6, 8, 14, 16. Each output comes 1 cycle after input pixels 6, 8, 14, 16. out_sof on 6; out_eol on 8 and 16; frame_done on 16.
- Signed values: block {-5, -3, -128, -1} -> -1; block {127, -128, 0, 0} -> 127.
- Bubbles: same frame as the basic case with in_valid low 3 cycles between every pixel -> identical output values and markers. Each out_valid is still 1 cycle after its trigger pixel.
- No sof after reset: 16 pixels without sof -> no out_valid. Then a proper frame -> normal output.
- Mid-frame sof: sof reissued at pixel 10 -> frame_err pulses once. Counters restart and the next 16 pixels give a correct 4-output frame. No output is produced from the aborted frame after pixel 10.
- MAXPOOL_AVG_EN defined: block {1, 2, 3, 5} -> 2; block {-1, -1, -1, -2} -> -2 (floor of -5/4). Reset asserted mid-row -> all outputs 0 and state WAIT_SOF.
